// File: rtl/rs_param_station.sv
// Parametrised reservation station: buffers dispatched ops, wakes operands from CDB_N buses,
// issues one ready entry per cycle into a registered valid/ready slot. Optional macro RS_AGE_ORDER_EN.
module rs_param_station #(
  parameter int DEPTH  = 16,
  parameter int CDB_N  = 2,
  parameter int DATA_W = 32,
  parameter int ROB_W  = 4,
  parameter int OP_W   = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rdy,
  input  logic                      flush,
  input  logic                      disp_valid,
  output logic                      disp_ready,
  input  logic [OP_W-1:0]           disp_op,
  input  logic [DATA_W-1:0]         disp_v1,
  input  logic [DATA_W-1:0]         disp_v2,
  input  logic [ROB_W-1:0]          disp_q1,
  input  logic [ROB_W-1:0]          disp_q2,
  input  logic [DATA_W-1:0]         disp_pc,
  input  logic [DATA_W-1:0]         disp_imm,
  input  logic [ROB_W-1:0]          disp_rob,
  input  logic [CDB_N-1:0]          cdb_valid,
  input  logic [CDB_N*ROB_W-1:0]    cdb_tag,
  input  logic [CDB_N*DATA_W-1:0]   cdb_data,
  output logic                      iss_valid,
  input  logic                      iss_ready,
  output logic [OP_W-1:0]           iss_op,
  output logic [DATA_W-1:0]         iss_v1,
  output logic [DATA_W-1:0]         iss_v2,
  output logic [DATA_W-1:0]         iss_pc,
  output logic [DATA_W-1:0]         iss_imm,
  output logic [ROB_W-1:0]          iss_rob,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  logic [DEPTH-1:0]  busy_reg;
  logic [OP_W-1:0]   op_reg  [DEPTH];
  logic [DATA_W-1:0] v1_reg  [DEPTH];
  logic [DATA_W-1:0] v2_reg  [DEPTH];
  logic [DATA_W-1:0] pc_reg  [DEPTH];
  logic [DATA_W-1:0] imm_reg [DEPTH];
  logic [ROB_W-1:0]  q1_reg  [DEPTH];
  logic [ROB_W-1:0]  q2_reg  [DEPTH];
  logic [ROB_W-1:0]  rob_reg [DEPTH];

  logic              iss_valid_reg;
  logic [OP_W-1:0]   iss_op_reg;
  logic [DATA_W-1:0] iss_v1_reg, iss_v2_reg, iss_pc_reg, iss_imm_reg;
  logic [ROB_W-1:0]  iss_rob_reg;
  logic [CNT_W-1:0]  count_reg;

  logic [DEPTH-1:0]  ready_vec, cand_vec;
  logic [DATA_W:0]   wake1 [DEPTH];
  logic [DATA_W:0]   wake2 [DEPTH];
  logic [DATA_W:0]   byp1, byp2;
  logic [IDX_W-1:0]  alloc_idx, sel_idx;
  logic              sel_any, load_en, take, alloc_fire;

  // Returns {hit, data}; descending scan so the lowest-numbered matching bus wins.
  function automatic logic [DATA_W:0] cdb_match(input logic [ROB_W-1:0] tag);
    logic [DATA_W:0] r;
    r = '0;
    for (int k = CDB_N - 1; k >= 0; k--) begin
      if (cdb_valid[k] && (tag != '0) && (cdb_tag[k*ROB_W +: ROB_W] == tag))
        r = {1'b1, cdb_data[k*DATA_W +: DATA_W]};
    end
    return r;
  endfunction

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      assign ready_vec[gi] = busy_reg[gi] && (q1_reg[gi] == '0) && (q2_reg[gi] == '0);
      assign wake1[gi]     = cdb_match(q1_reg[gi]);
      assign wake2[gi]     = cdb_match(q2_reg[gi]);
    end
  endgenerate

  assign byp1       = cdb_match(disp_q1);
  assign byp2       = cdb_match(disp_q2);
  assign disp_ready = ~&busy_reg;
  assign alloc_fire = disp_valid && disp_ready;
  assign load_en    = !iss_valid_reg || iss_ready;
  assign take       = load_en && sel_any;

  always_comb begin
    alloc_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!busy_reg[i]) alloc_idx = IDX_W'(i);
    end
  end

  always_comb begin
    sel_idx = '0;
    sel_any = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (cand_vec[i]) begin
        sel_idx = IDX_W'(i);
        sel_any = 1'b1;
      end
    end
  end

`ifdef RS_AGE_ORDER_EN
  // age_reg[i][j] set means entry j is older than entry i.
  logic [DEPTH-1:0] age_reg [DEPTH];
  logic [DEPTH-1:0] free_vec;

  always_comb begin
    free_vec = '0;
    if (take) free_vec[sel_idx] = 1'b1;
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_age
      assign cand_vec[gi] = ready_vec[gi] && ((age_reg[gi] & ready_vec) == '0);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) age_reg[i] <= '0;
    end else if (rdy) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (flush)
          age_reg[i] <= '0;
        else if (alloc_fire && (alloc_idx == IDX_W'(i)))
          age_reg[i] <= busy_reg & ~free_vec;
        else
          age_reg[i] <= age_reg[i] & ~free_vec;
      end
    end
  end
`else
  assign cand_vec = ready_vec;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_reg      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q1_reg[i] <= '0;
        q2_reg[i] <= '0;
      end
      iss_valid_reg <= 1'b0;
      iss_op_reg    <= '0;
      iss_v1_reg    <= '0;
      iss_v2_reg    <= '0;
      iss_pc_reg    <= '0;
      iss_imm_reg   <= '0;
      iss_rob_reg   <= '0;
      count_reg     <= '0;
    end else if (rdy) begin
      if (flush) begin
        busy_reg      <= '0;
        for (int i = 0; i < DEPTH; i++) begin
          q1_reg[i] <= '0;
          q2_reg[i] <= '0;
        end
        iss_valid_reg <= 1'b0;
        iss_op_reg    <= '0;
        count_reg     <= '0;
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          if (busy_reg[i] && wake1[i][DATA_W]) begin
            v1_reg[i] <= wake1[i][DATA_W-1:0];
            q1_reg[i] <= '0;
          end
          if (busy_reg[i] && wake2[i][DATA_W]) begin
            v2_reg[i] <= wake2[i][DATA_W-1:0];
            q2_reg[i] <= '0;
          end
        end
        if (take) begin
          busy_reg[sel_idx] <= 1'b0;
          iss_valid_reg     <= 1'b1;
          iss_op_reg        <= op_reg[sel_idx];
          iss_v1_reg        <= v1_reg[sel_idx];
          iss_v2_reg        <= v2_reg[sel_idx];
          iss_pc_reg        <= pc_reg[sel_idx];
          iss_imm_reg       <= imm_reg[sel_idx];
          iss_rob_reg       <= rob_reg[sel_idx];
        end else if (load_en) begin
          iss_valid_reg <= 1'b0;
          iss_op_reg    <= '0;
        end
        // Allocation only targets free entries, so it never collides with wakeup or issue.
        if (alloc_fire) begin
          busy_reg[alloc_idx] <= 1'b1;
          op_reg[alloc_idx]   <= disp_op;
          v1_reg[alloc_idx]   <= byp1[DATA_W] ? byp1[DATA_W-1:0] : disp_v1;
          v2_reg[alloc_idx]   <= byp2[DATA_W] ? byp2[DATA_W-1:0] : disp_v2;
          q1_reg[alloc_idx]   <= byp1[DATA_W] ? '0 : disp_q1;
          q2_reg[alloc_idx]   <= byp2[DATA_W] ? '0 : disp_q2;
          pc_reg[alloc_idx]   <= disp_pc;
          imm_reg[alloc_idx]  <= disp_imm;
          rob_reg[alloc_idx]  <= disp_rob;
        end
        count_reg <= count_reg + CNT_W'(alloc_fire) - CNT_W'(take);
      end
    end
  end

  assign iss_valid = iss_valid_reg;
  assign iss_op    = iss_op_reg;
  assign iss_v1    = iss_v1_reg;
  assign iss_v2    = iss_v2_reg;
  assign iss_pc    = iss_pc_reg;
  assign iss_imm   = iss_imm_reg;
  assign iss_rob   = iss_rob_reg;
  assign count     = count_reg;

endmodule

// File: tb/tb_rs_param_station.sv
// Self-checking bench for rs_param_station: dispatch vector table plus multi-cycle sequences,
// with issued instructions checked against a scoreboard queue.
module tb_rs_param_station;

  logic        clk = 1'b0;
  logic        rst, rdy, flush, disp_valid, disp_ready;
  logic [5:0]  disp_op;
  logic [31:0] disp_v1, disp_v2, disp_pc, disp_imm;
  logic [3:0]  disp_q1, disp_q2, disp_rob;
  logic [1:0]  cdb_valid;
  logic [7:0]  cdb_tag;
  logic [63:0] cdb_data;
  logic        iss_valid, iss_ready;
  logic [5:0]  iss_op;
  logic [31:0] iss_v1, iss_v2, iss_pc, iss_imm;
  logic [3:0]  iss_rob;
  logic [4:0]  count;

  rs_param_station dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op),
    .disp_v1(disp_v1), .disp_v2(disp_v2), .disp_q1(disp_q1), .disp_q2(disp_q2),
    .disp_pc(disp_pc), .disp_imm(disp_imm), .disp_rob(disp_rob),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_op(iss_op),
    .iss_v1(iss_v1), .iss_v2(iss_v2), .iss_pc(iss_pc), .iss_imm(iss_imm),
    .iss_rob(iss_rob), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] v1, v2, pc, imm;
    logic [3:0]  rob;
  } iss_t;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] v1, v2;
    logic [3:0]  q1, q2;
    logic [31:0] pc, imm;
    logic [3:0]  rob;
    logic [1:0]  cv;
    logic [3:0]  t0, t1;
    logic [31:0] d0, d1;
    logic [31:0] e1, e2;
  } vec_t;

  iss_t sb_q[$];
  iss_t mon_e;
  int   tests = 0;
  int   fails = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic disp(input logic [5:0] op, input logic [31:0] v1, input logic [31:0] v2,
                      input logic [3:0] q1, input logic [3:0] q2, input logic [31:0] pc,
                      input logic [31:0] imm, input logic [3:0] rob);
    disp_valid = 1'b1; disp_op = op; disp_v1 = v1; disp_v2 = v2;
    disp_q1 = q1; disp_q2 = q2; disp_pc = pc; disp_imm = imm; disp_rob = rob;
  endtask

  task automatic push_exp(input logic [5:0] op, input logic [31:0] v1, input logic [31:0] v2,
                          input logic [31:0] pc, input logic [31:0] imm, input logic [3:0] rob);
    iss_t e;
    e.op = op; e.v1 = v1; e.v2 = v2; e.pc = pc; e.imm = imm; e.rob = rob;
    sb_q.push_back(e);
  endtask

  task automatic cdb(input logic [1:0] cv, input logic [3:0] t0, input logic [31:0] d0,
                     input logic [3:0] t1, input logic [31:0] d1);
    cdb_valid = cv; cdb_tag = {t1, t0}; cdb_data = {d1, d0};
  endtask

  task automatic idle_in();
    disp_valid = 1'b0; flush = 1'b0; cdb_valid = 2'b00;
  endtask

  task automatic drain(input string name, input int budget, output int used);
    int k = 0;
    while (sb_q.size() != 0 && k < budget) begin
      tick();
      k++;
    end
    used = k;
    tests++;
    if (sb_q.size() != 0) begin
      fails++;
      $display("FAIL %s: %0d issues still pending after %0d cycles", name, sb_q.size(), k);
      sb_q.delete();
    end
  endtask

  // Issue monitor: a handshake seen at the negedge is taken at the following posedge.
  always @(negedge clk) begin
    if (!rst && rdy && !flush && iss_valid && iss_ready) begin
      tests++;
      if (sb_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_issue: got op=%0h rob=%0h required no issue", iss_op, iss_rob);
      end else begin
        mon_e = sb_q.pop_front();
        if ({iss_op, iss_v1, iss_v2, iss_pc, iss_imm, iss_rob} !==
            {mon_e.op, mon_e.v1, mon_e.v2, mon_e.pc, mon_e.imm, mon_e.rob}) begin
          fails++;
          $display("FAIL issue: got op=%0h v1=%0h v2=%0h pc=%0h imm=%0h rob=%0h required op=%0h v1=%0h v2=%0h pc=%0h imm=%0h rob=%0h",
                   iss_op, iss_v1, iss_v2, iss_pc, iss_imm, iss_rob,
                   mon_e.op, mon_e.v1, mon_e.v2, mon_e.pc, mon_e.imm, mon_e.rob);
        end else begin
          $display("[TB] issue op=%0h v1=%0h v2=%0h pc=%0h imm=%0h rob=%0h",
                   iss_op, iss_v1, iss_v2, iss_pc, iss_imm, iss_rob);
        end
      end
    end
  end

  vec_t vecs [6];

  initial begin
    int used;
    // op, v1, v2, q1, q2, pc, imm, rob, cdb_valid, t0, t1, d0, d1, exp_v1, exp_v2
    vecs[0] = '{6'h05, 32'h3, 32'h4, 4'd0, 4'd0, 32'h100, 32'h8, 4'd2, 2'b00, 4'd0, 4'd0, 32'h0, 32'h0, 32'h3, 32'h4};
    vecs[1] = '{6'h09, 32'h1, 32'h2, 4'd0, 4'd3, 32'h104, 32'h1, 4'd3, 2'b01, 4'd3, 4'd0, 32'h55, 32'h0, 32'h1, 32'h55};
    vecs[2] = '{6'h11, 32'h7, 32'h8, 4'd4, 4'd0, 32'h108, 32'h2, 4'd4, 2'b10, 4'd0, 4'd4, 32'h0, 32'h66, 32'h66, 32'h8};
    vecs[3] = '{6'h12, 32'h9, 32'hA, 4'd5, 4'd5, 32'h10C, 32'h3, 4'd5, 2'b11, 4'd5, 4'd5, 32'hA1, 32'hB2, 32'hA1, 32'hA1};
    vecs[4] = '{6'h13, 32'h10, 32'h20, 4'd0, 4'd0, 32'h110, 32'h4, 4'd6, 2'b11, 4'd0, 4'd0, 32'hDEAD, 32'hBEEF, 32'h10, 32'h20};
    vecs[5] = '{6'h3F, 32'hB, 32'hC, 4'd6, 4'd2, 32'h114, 32'h5, 4'd7, 2'b11, 4'd2, 4'd6, 32'h22, 32'h66, 32'h66, 32'h22};

    rst = 1'b1; rdy = 1'b1; iss_ready = 1'b1;
    idle_in();
    disp_op = '0; disp_v1 = '0; disp_v2 = '0; disp_q1 = '0; disp_q2 = '0;
    disp_pc = '0; disp_imm = '0; disp_rob = '0; cdb_tag = '0; cdb_data = '0;
    tick(); tick();
    check("reset_iss_valid", iss_valid, 0);
    check("reset_iss_fields", {iss_op, iss_v1, iss_v2, iss_pc, iss_imm, iss_rob}, 0);
    check("reset_count", count, 0);
    check("reset_disp_ready", disp_ready, 1);
    rst = 1'b0;
    tick();

    // Single dispatches resolved at dispatch time (plain ready, CDB bypass, bus priority, tag 0).
    for (int i = 0; i < 6; i++) begin
      disp(vecs[i].op, vecs[i].v1, vecs[i].v2, vecs[i].q1, vecs[i].q2, vecs[i].pc, vecs[i].imm, vecs[i].rob);
      cdb(vecs[i].cv, vecs[i].t0, vecs[i].d0, vecs[i].t1, vecs[i].d1);
      push_exp(vecs[i].op, vecs[i].e1, vecs[i].e2, vecs[i].pc, vecs[i].imm, vecs[i].rob);
      tick();
      idle_in();
      check($sformatf("vec%0d_count_after_disp", i), count, 1);
      check($sformatf("vec%0d_not_yet_valid", i), iss_valid, 0);
      tick();
      check($sformatf("vec%0d_valid_op", i), {iss_valid, iss_op}, {1'b1, vecs[i].op});
      check($sformatf("vec%0d_count_after_issue", i), count, 0);
      tick();
      check($sformatf("vec%0d_scoreboard_empty", i), sb_q.size(), 0);
      check($sformatf("vec%0d_slot_empty", i), {iss_valid, iss_op}, 0);
    end

    // Fill every entry waiting on tag 7, then wake them all from bus 1.
    for (int i = 0; i < 16; i++) begin
      disp(6'(i + 1), 32'(i), 32'(i * 2), 4'd7, 4'd0, 32'(i * 4), 32'(i + 100), 4'(i));
      push_exp(6'(i + 1), 32'hAB, 32'(i * 2), 32'(i * 4), 32'(i + 100), 4'(i));
      tick();
    end
    idle_in();
    check("full_count", count, 16);
    check("full_disp_ready", disp_ready, 0);
    check("full_no_issue", iss_valid, 0);
    cdb(2'b10, 4'd0, 32'h0, 4'd7, 32'hAB);
    tick();
    idle_in();
    drain("fill_drain", 40, used);
    check("b2b_cycles", used, 17);
    check("fill_count_empty", count, 0);

    // Slot hold with iss_ready low.
    iss_ready = 1'b0;
    disp(6'h21, 32'h1111, 32'h2222, 4'd0, 4'd0, 32'h40, 32'h1, 4'd3);
    push_exp(6'h21, 32'h1111, 32'h2222, 32'h40, 32'h1, 4'd3);
    tick();
    disp(6'h22, 32'h3333, 32'h4444, 4'd0, 4'd0, 32'h44, 32'h2, 4'd4);
    push_exp(6'h22, 32'h3333, 32'h4444, 32'h44, 32'h2, 4'd4);
    tick();
    idle_in();
    for (int c = 0; c < 6; c++) begin
      check($sformatf("hold_cycle%0d", c), {iss_valid, iss_op, iss_v1, iss_v2, iss_rob},
            {1'b1, 6'h21, 32'h1111, 32'h2222, 4'd3});
      check($sformatf("hold_count%0d", c), count, 1);
      if (c < 5) tick();
    end
    iss_ready = 1'b1;
    tick();
    check("hold_next_loaded", {iss_valid, iss_op, iss_rob}, {1'b1, 6'h22, 4'd4});
    tick();
    check("hold_scoreboard_empty", sb_q.size(), 0);

    // Selection order: A at index 3, B later at index 0, both woken together.
    disp(6'h31, 32'h0, 32'h0, 4'd6, 4'd0, 32'h0, 32'h0, 4'd1); tick();
    disp(6'h32, 32'h0, 32'h0, 4'd9, 4'd0, 32'h0, 32'h0, 4'd2); tick();
    disp(6'h33, 32'h0, 32'h0, 4'd9, 4'd0, 32'h0, 32'h0, 4'd3); tick();
    disp(6'h3A, 32'h0, 32'h0, 4'd5, 4'd0, 32'h0, 32'h0, 4'hA); tick();
    idle_in();
    check("age_count4", count, 4);
    push_exp(6'h31, 32'h66, 32'h0, 32'h0, 32'h0, 4'd1);
    cdb(2'b01, 4'd6, 32'h66, 4'd0, 32'h0);
    tick();
    idle_in();
    drain("age_free0", 10, used);
    check("age_count3", count, 3);
    disp(6'h3B, 32'h0, 32'h0, 4'd5, 4'd0, 32'h0, 32'h0, 4'hB); tick();
    idle_in();
    check("age_count4b", count, 4);
`ifdef RS_AGE_ORDER_EN
    push_exp(6'h3A, 32'h77, 32'h0, 32'h0, 32'h0, 4'hA);
    push_exp(6'h3B, 32'h77, 32'h0, 32'h0, 32'h0, 4'hB);
`else
    push_exp(6'h3B, 32'h77, 32'h0, 32'h0, 32'h0, 4'hB);
    push_exp(6'h3A, 32'h77, 32'h0, 32'h0, 32'h0, 4'hA);
`endif
    cdb(2'b01, 4'd5, 32'h77, 4'd0, 32'h0);
    tick();
    idle_in();
    drain("age_order", 10, used);
    check("age_count2", count, 2);

    // Flush with four busy entries and a held slot; the same-cycle dispatch is dropped.
    iss_ready = 1'b0;
    disp(6'h01, 32'h0, 32'h0, 4'd0, 4'd0, 32'h0, 32'h0, 4'd1); tick();
    disp(6'h02, 32'h0, 32'h0, 4'd0, 4'd0, 32'h0, 32'h0, 4'd2); tick();
    disp(6'h03, 32'h0, 32'h0, 4'd0, 4'd0, 32'h0, 32'h0, 4'd3); tick();
    idle_in();
    check("preflush_count", count, 4);
    check("preflush_slot", {iss_valid, iss_op}, {1'b1, 6'h01});
    flush = 1'b1;
    disp(6'h04, 32'h0, 32'h0, 4'd0, 4'd0, 32'h0, 32'h0, 4'd4);
    tick();
    idle_in();
    check("flush_count", count, 0);
    check("flush_slot", {iss_valid, iss_op}, 0);
    check("flush_disp_ready", disp_ready, 1);
    iss_ready = 1'b1;
    tick(); tick();
    check("flush_dispatch_dropped", {iss_valid, count}, 0);

    // rdy low freezes everything, including dispatch.
    rdy = 1'b0;
    disp(6'h05, 32'h1, 32'h2, 4'd0, 4'd0, 32'h0, 32'h0, 4'd5);
    tick(); tick();
    check("frozen_count", count, 0);
    check("frozen_slot", iss_valid, 0);
    idle_in();
    rdy = 1'b1;
    tick();
    check("unfrozen_count", count, 0);
    check("final_scoreboard_empty", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rs_param_station.md
# rs_param_station

Parametrised reservation station for the out-of-order core's arithmetic pipe. It buffers dispatched instructions, wakes pending operands from CDB_N result buses, and selects one ready entry per cycle into a registered issue slot. The issue slot uses a valid/ready handshake toward the ALU. It sits between the dispatcher and the ALU, and generalises the fixed 16-entry, two-bus station.

## Interface
- DEPTH, 16: entry count (power of two, 2..64)
- CDB_N, 2: number of broadcast result buses
- DATA_W, 32: operand/pc/imm width
- ROB_W, 4: ROB tag width; tag 0 means "operand ready / no producer"
- OP_W, 6: opcode width; opcode 0 is NOP
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rdy  in  1  global enable; low freezes all state
- flush  in  1  misprediction flush
- disp_valid  in  1  dispatch request
- disp_ready  out  1  a free entry exists
- disp_op  in  OP_W  opcode
- disp_v1, disp_v2  in  DATA_W  operand values
- disp_q1, disp_q2  in  ROB_W  operand producer tags
- disp_pc, disp_imm  in  DATA_W  pc, immediate
- disp_rob  in  ROB_W  destination ROB tag
- cdb_valid  in  CDB_N  per-bus valid
- cdb_tag  in  CDB_N*ROB_W  per-bus tag; bus k at bits [k*ROB_W +: ROB_W]
- cdb_data  in  CDB_N*DATA_W  per-bus result
- iss_valid  out  1  issue slot holds an instruction
- iss_ready  in  1  ALU accepts the slot this cycle
- iss_op, iss_v1, iss_v2, iss_pc, iss_imm, iss_rob  out  as dispatch  issued fields
- count  out  $clog2(DEPTH)+1  occupied entries, issue slot excluded

## Operation
- Entry fields: busy, op, v1, v2, q1, q2, pc, imm, rob.
- An entry is ready when busy, q1==0 and q2==0.
- Allocation: on disp_valid && disp_ready, write the lowest-index free entry.
- Dispatch bypass: a disp_qX matching any valid CDB tag in the same cycle is stored as qX=0, with vX taken from that bus.
- Wakeup: every cycle, each busy entry with qX==cdb_tag[k] (cdb_valid[k], tag≠0) gets vX<=cdb_data[k] and qX<=0.
- Multiple buses matching one tag: lowest k wins. cdb_tag==0 never matches.
- Slot load: when !iss_valid || iss_ready, the selected ready entry is copied into the issue slot and freed in the same edge.
- If no entry is ready at a load opportunity: iss_valid<=0 and iss_op<=0.
- Slot hold: while iss_valid && !iss_ready, all iss_* outputs are held stable.
- disp_ready = !(all entries busy). It is computed from registered state only; an entry freed this cycle becomes usable next cycle.
- Simultaneous dispatch and slot load into the same index cannot occur: allocation uses only non-busy entries.
- flush (when rdy=1): next edge clears every busy bit, q tags and iss_valid, sets iss_op=0, and drops any same-cycle dispatch. Priority: rst > flush > normal operation.
- rdy=0: no state changes. CDB inputs are ignored, because their producers are frozen too.

## Timing
- Reset values: iss_valid=0; iss_op=0; iss_v1, iss_v2, iss_pc, iss_imm, iss_rob all 0; count=0; disp_ready=1; all entries free.
- Dispatch with ready operands at edge t: iss_valid=1 after edge t+1. Minimum latency is 2 cycles.
- CDB broadcast at edge t wakes a waiting entry; it can load into the slot at edge t+1.
- count updates at the same edge as the allocate/free; +1, -1 or 0 net.
- Back-to-back issue at one instruction per cycle while iss_ready=1 and ready entries exist.

## Configuration
- RS_AGE_ORDER_EN defined: selection is oldest ready entry first.
  - Uses a DEPTH×DEPTH age matrix. Row i is set on allocate to mark all currently busy entries as older. Column i is cleared on free.
- RS_AGE_ORDER_EN undefined: selection is lowest-index ready entry. No age storage is built.

## Test plan
- Reset, then dispatch op=5, q1=q2=0, v1=3, v2=4, rob=2, with iss_ready=1 → iss_valid=1 two edges later, iss_op=5, iss_v1=3, iss_v2=4, iss_rob=2; count returns to 0.
- Fill DEPTH entries with q1=7 → disp_ready=0 and count=DEPTH. Then broadcast tag 7, data 0xAB on bus 1 → all entries wake; DEPTH issues follow, each with iss_v1=0xAB.
- Dispatch q2=3 in the same cycle as cdb_valid[0]=1, tag 3, data 0x55 → entry stored ready and issues with iss_v2=0x55 without further broadcast.
- Hold iss_ready=0 for 5 cycles with the slot valid → iss_* stable throughout; next ready entry appears the cycle after iss_ready=1.
- With RS_AGE_ORDER_EN: dispatch A into index 3, free index 0, dispatch B into index 0, wake both in the same cycle → A issues before B. With the macro undefined → B issues first.
- Assert flush with 4 busy entries and the slot valid → next cycle count=0, iss_valid=0, disp_ready=1; a dispatch in the flush cycle is discarded.
